median3x3_filter: RTL and testbench

- Consumes the current pixel plus the two delayed-line taps from the line shift buffer (current row, row-1, row-2).
- Assembles a 3x3 window and outputs its median, which suppresses salt-and-pepper noise before segmentation in the fruit-recognition pipeline.
- Sync strobes are delayed to match the data path exactly, so downstream stages see an aligned stream.

---
 rtl/median3x3_filter.sv | 169 ++++++++++++++++
 tb/tb_median3x3_filter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/median3x3_filter.sv
// 3x3 median filter for a line-buffered pixel stream.
// Stage 0 assembles the window, S1 sorts each column, S2 reduces the
// sorted columns, S3 picks the median. Sync strobes ride a matching
// 4-deep delay line so the output stream stays aligned.
module median3x3_filter #(
   parameter int DATA_W      = 8,
   parameter int COL_W       = 10,
   parameter int BORDER_MODE = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_de,
   input  logic              in_hs,
   input  logic              in_vs,
   input  logic [DATA_W-1:0] pix_r0,
   input  logic [DATA_W-1:0] pix_r1,
   input  logic [DATA_W-1:0] pix_r2,
   output logic              med_de,
   output logic              med_hs,
   output logic              med_vs,
   output logic [DATA_W-1:0] med_data
);

   localparam int STAGES = 4;

   typedef logic [DATA_W-1:0] pix_t;

   function automatic pix_t max2(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic pix_t min2(input pix_t a, input pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
      return max2(max2(a, b), c);
   endfunction

   function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
      return min2(min2(a, b), c);
   endfunction

   function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   // window: r_win[col][row], col 0 is the newest column, row 0 the current row
   logic [2:0][2:0][DATA_W-1:0] r_win;
   logic                        r_vld0;
   logic [COL_W-1:0]            r_col_cnt;
   logic [1:0]                  r_row_cnt;
   logic [STAGES-1:0]           r_de_pipe, r_hs_pipe, r_vs_pipe;

   logic [2:0][DATA_W-1:0]      r_s1_max, r_s1_mid, r_s1_min;
   pix_t                        r_s1_cen;
   logic                        r_s1_vld;

   pix_t                        r_s2_min_of_max, r_s2_mid_of_mid, r_s2_max_of_min;
   pix_t                        r_s2_cen;
   logic                        r_s2_vld;

   pix_t                        r_med_data;

   logic                        w_win_ok;
   logic                        w_hs_fall;

   // window is valid once two full columns and two full rows precede this sample
   assign w_win_ok  = (r_col_cnt >= COL_W'(2)) && (r_row_cnt >= 2'd2);
   assign w_hs_fall = r_hs_pipe[0] && !in_hs;

   // sync strobe delay lines; stage 0 of hs also serves as the edge detector
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_de_pipe <= '0;
         r_hs_pipe <= '0;
         r_vs_pipe <= '0;
      end else begin
         r_de_pipe <= {r_de_pipe[STAGES-2:0], in_de};
         r_hs_pipe <= {r_hs_pipe[STAGES-2:0], in_hs};
         r_vs_pipe <= {r_vs_pipe[STAGES-2:0], in_vs};
      end
   end

   // column/row position counters; blanking clears take priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col_cnt <= '0;
         r_row_cnt <= '0;
      end else begin
         if (!in_hs)
            r_col_cnt <= '0;
         else if (in_de && (r_col_cnt != {COL_W{1'b1}}))
            r_col_cnt <= r_col_cnt + 1'b1;

         if (!in_vs)
            r_row_cnt <= '0;
         else if (w_hs_fall && (r_row_cnt != 2'd3))
            r_row_cnt <= r_row_cnt + 1'b1;
      end
   end

   // stage 0: shift a new column into the window on each valid pixel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_win  <= '0;
         r_vld0 <= 1'b0;
      end else if (in_de) begin
         r_win  <= {r_win[1], r_win[0], {pix_r2, pix_r1, pix_r0}};
         r_vld0 <= w_win_ok;
      end
   end

   // S1: sort each column into max/mid/min, carry centre and valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_max <= '0;
         r_s1_mid <= '0;
         r_s1_min <= '0;
         r_s1_cen <= '0;
         r_s1_vld <= 1'b0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            r_s1_max[c] <= max3(r_win[c][0], r_win[c][1], r_win[c][2]);
            r_s1_mid[c] <= med3(r_win[c][0], r_win[c][1], r_win[c][2]);
            r_s1_min[c] <= min3(r_win[c][0], r_win[c][1], r_win[c][2]);
         end
         r_s1_cen <= r_win[1][1];
         r_s1_vld <= r_vld0;
      end
   end

   // S2: reduce sorted columns to the three median candidates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_min_of_max <= '0;
         r_s2_mid_of_mid <= '0;
         r_s2_max_of_min <= '0;
         r_s2_cen        <= '0;
         r_s2_vld        <= 1'b0;
      end else begin
         r_s2_min_of_max <= min3(r_s1_max[0], r_s1_max[1], r_s1_max[2]);
         r_s2_mid_of_mid <= med3(r_s1_mid[0], r_s1_mid[1], r_s1_mid[2]);
         r_s2_max_of_min <= max3(r_s1_min[0], r_s1_min[1], r_s1_min[2]);
         r_s2_cen        <= r_s1_cen;
         r_s2_vld        <= r_s1_vld;
      end
   end

   // S3: final median or border pixel; holds between valid output pixels
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_med_data <= '0;
      else if (r_de_pipe[STAGES-2]) begin
         if (r_s2_vld)
            r_med_data <= med3(r_s2_min_of_max, r_s2_mid_of_mid, r_s2_max_of_min);
         else if (BORDER_MODE == 1)
            r_med_data <= '0;
         else
            r_med_data <= r_s2_cen;
      end
   end

   assign med_de   = r_de_pipe[STAGES-1];
   assign med_hs   = r_hs_pipe[STAGES-1];
   assign med_vs   = r_vs_pipe[STAGES-1];
   assign med_data = r_med_data;

endmodule

// File: tb/tb_median3x3_filter.sv
// Randomized bench for median3x3_filter: both border modes run side by
// side against a window/sort reference model and a strobe history.
module tb_median3x3_filter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_de = 1'b0, in_hs = 1'b0, in_vs = 1'b0;
   logic [7:0] p0 = '0, p1 = '0, p2 = '0;
   logic       de0, hs0, vs0, de1, hs1, vs1;
   logic [7:0] d0, d1;

   median3x3_filter #(.DATA_W(8), .COL_W(10), .BORDER_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
      .pix_r0(p0), .pix_r1(p1), .pix_r2(p2),
      .med_de(de0), .med_hs(hs0), .med_vs(vs0), .med_data(d0));

   median3x3_filter #(.DATA_W(8), .COL_W(10), .BORDER_MODE(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
      .pix_r0(p0), .pix_r1(p1), .pix_r2(p2),
      .med_de(de1), .med_hs(hs1), .med_vs(vs1), .med_data(d1));

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [7:0] e0;
      logic [7:0] e1;
      logic       ramp;
      logic       vld;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] hq[$];
   logic [7:0] win[3][3];   // win[col][row], col 0 newest
   int         mcol, mrow;
   logic       mhs;
   logic [7:0] last0, last1;
   logic       ramp_on;
   int         kcol;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] median9();
      int a[9];
      int t;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 3; r++)
            a[c*3+r] = int'(win[c][r]);
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (a[j] > a[j+1]) begin
               t = a[j]; a[j] = a[j+1]; a[j+1] = t;
            end
      return 8'(a[4]);
   endfunction

   task automatic model_clear();
      sb.delete();
      hq.delete();
      repeat (4) hq.push_back(3'b000);
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 3; r++)
            win[c][r] = 8'h00;
      mcol = 0; mrow = 0; mhs = 1'b0;
      last0 = 8'h00; last1 = 8'h00;
   endtask

   task automatic check_out();
      logic [2:0] h;
      exp_t       e;
      h = hq.pop_front();
      chk("de0", de0, h[2]); chk("hs0", hs0, h[1]); chk("vs0", vs0, h[0]);
      chk("de1", de1, h[2]); chk("hs1", hs1, h[1]); chk("vs1", vs1, h[0]);
      if (de0) begin
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("med0", d0, e.e0);
            chk("med1", d1, e.e1);
            if (e.ramp && e.vld) chk("ramp5", d0, 8'd5);
            last0 = e.e0;
            last1 = e.e1;
         end
      end else begin
         chk("hold0", d0, last0);
         chk("hold1", d1, last1);
      end
   endtask

   // one clock: check outputs, drive the next sample, advance the model
   task automatic step(input logic de, input logic hs, input logic vs,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      exp_t       e;
      logic       vld;
      logic [7:0] m;
      @(negedge clk);
      check_out();
      in_de = de; in_hs = hs; in_vs = vs;
      p0 = a; p1 = b; p2 = c;
      if (de) begin
         vld = (mcol >= 2) && (mrow >= 2);
         for (int r = 0; r < 3; r++) begin
            win[2][r] = win[1][r];
            win[1][r] = win[0][r];
         end
         win[0][0] = a; win[0][1] = b; win[0][2] = c;
         m = median9();
         e.e0   = vld ? m : win[1][1];
         e.e1   = vld ? m : 8'h00;
         e.ramp = ramp_on;
         e.vld  = vld;
         sb.push_back(e);
      end
      if (!hs) mcol = 0;
      else if (de && mcol < 1023) mcol++;
      if (!vs) mrow = 0;
      else if (mhs && !hs && mrow < 3) mrow++;
      mhs = hs;
      hq.push_back({de, hs, vs});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_de = 1'b0; in_hs = 1'b0; in_vs = 1'b0;
      p0 = '0; p1 = '0; p2 = '0;
      #1;
      chk("rst_de", {de1, de0}, 2'b00);
      chk("rst_hs", {hs1, hs0}, 2'b00);
      chk("rst_vs", {vs1, vs0}, 2'b00);
      chk("rst_d0", d0, 8'h00);
      chk("rst_d1", d1, 8'h00);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic gen_pix(input int mode, output logic [7:0] a, output logic [7:0] b,
                          output logic [7:0] c);
      logic [7:0] v[3];
      logic [7:0] t;
      int         j;
      logic [7:0] pal[4];
      pal[0] = 8'h00; pal[1] = 8'hAA; pal[2] = 8'hFF; pal[3] = 8'h10;
      case (mode)
         0: begin v[0] = 8'h40; v[1] = 8'h40; v[2] = 8'h40; end
         1: begin v[0] = 8'($urandom); v[1] = 8'($urandom); v[2] = 8'($urandom); end
         2: for (int i = 0; i < 3; i++) v[i] = pal[$urandom_range(0, 3)];
         3: begin
            for (int i = 0; i < 3; i++) v[i] = 8'(3 * (kcol % 3) + 1 + i);
            for (int i = 2; i > 0; i--) begin
               j = $urandom_range(0, i);
               t = v[i]; v[i] = v[j]; v[j] = t;
            end
         end
         default: begin v[0] = 8'h00; v[1] = kcol[0] ? 8'hAA : 8'h00; v[2] = 8'h00; end
      endcase
      a = v[0]; b = v[1]; c = v[2];
   endtask

   task automatic frame(input int lines, input int cols, input int mode, input int gap_pct,
                        input int rl, input int rc);
      logic [7:0] a, b, c;
      ramp_on = (mode == 3);
      repeat (2) step(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      for (int l = 0; l < lines; l++) begin
         for (int k = 0; k < cols; k++) begin
            if (l == rl && k == rc) begin
               do_reset();
               return;
            end
            if (int'($urandom_range(0, 99)) < gap_pct)
               repeat ($urandom_range(1, 2))
                  step(1'b0, 1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            kcol = k;
            gen_pix(mode, a, b, c);
            step(1'b1, 1'b1, 1'b1, a, b, c);
         end
         repeat (3) step(1'b0, 1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      model_clear();
      ramp_on = 1'b0;
      kcol = 0;
      do_reset();
      frame(6, 40, 0, 0, -1, -1);     // flat field
      frame(6, 40, 1, 0, -1, -1);     // random pixels
      frame(6, 40, 1, 30, -1, -1);    // random with de gaps
      frame(5, 30, 2, 20, -1, -1);    // impulse-style palette
      frame(6, 30, 3, 0, -1, -1);     // permuted ramp windows
      frame(2, 30, 1, 0, -1, -1);     // short frame, border only
      frame(3, 1100, 1, 0, -1, -1);   // column counter saturation
      frame(8, 40, 1, 10, 4, 20);     // reset mid-line
      frame(5, 30, 4, 0, -1, -1);     // centre 0xAA among zeros
      repeat (6) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
